ov7670_config_sequencer: RTL and testbench

- Walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry into a register write command for the downstream SCCB transmitter.
- Entry format: {reg_addr[15:8], reg_data[7:0]}. 16'h00F0 is a timed delay. 16'hFFFF marks end of table.
- Sits between the config ROM (1-cycle registered read) and the SCCB transmitter (valid/ready command port). Runs once per start_i pulse and reports completion to camera bring-up logic.

---
 rtl/ov7670_config_sequencer.sv | 140 ++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM and issues one SCCB register write per entry,
// honouring timed-delay (16'h00F0) and end-of-table (16'hFFFF) markers.
module ov7670_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned MAX_ADDR     = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [7:0]  cmd_reg_o,
  output logic [7:0]  cmd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  write_count_o
);

  localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [7:0]  LAST_ADDR   = 8'(MAX_ADDR);
  localparam logic [15:0] ENTRY_DELAY = 16'h00F0;
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_reg_q, cmd_reg_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       wcount_q, wcount_d;
  logic             advance;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    wcount_d    = wcount_q;
    advance     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          addr_d   = 8'd0;
          wcount_d = 8'd0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data_i == ENTRY_END) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rom_data_i == ENTRY_DELAY) begin
          cnt_d   = DELAY_LOAD;
          state_d = S_DELAY;
        end else begin
          cmd_reg_d   = rom_data_i[15:8];
          cmd_data_d  = rom_data_i[7:0];
          cmd_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // Command stays frozen until the transmitter takes it.
        if (cmd_valid_q && cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          if (wcount_q != 8'hFF) wcount_d = wcount_q + 8'd1;
          advance = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Last ROM address ends the walk; the address never wraps.
    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 8'd1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'd0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_reg_q   <= 8'd0;
      cmd_data_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wcount_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wcount_q    <= wcount_d;
    end
  end

  assign rom_addr_o    = addr_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_reg_o     = cmd_reg_q;
  assign cmd_data_o    = cmd_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign write_count_o = wcount_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: table of small ROM images, hand-written timing
// sequences, and randomized ROMs/back-pressure compared against a command-list model.
module tb_ov7670_config_sequencer;

  localparam int DLY  = 5;
  localparam int MAXA = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cmd_valid;
  logic        ready;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        busy;
  logic        done;
  logic [7:0]  wcount;

  ov7670_config_sequencer #(.DELAY_CYCLES(DLY), .MAX_ADDR(MAXA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(ready),
    .cmd_reg_o(cmd_reg), .cmd_data_o(cmd_data),
    .busy_o(busy), .done_o(done), .write_count_o(wcount)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] acc_q[$];
  logic [15:0] exp_q[$];
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
  end

  // Acceptance monitor plus hold-while-stalled protocol check
  logic        pv, pr;
  logic [15:0] pc;
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
      pr <= 1'b0;
      pc <= 16'h0;
    end else begin
      if (cmd_valid && ready) acc_q.push_back({cmd_reg, cmd_data});
      if (pv && !pr) begin
        check("hold_valid", 32'(cmd_valid), 1);
        check("hold_cmd", 32'({cmd_reg, cmd_data}), 32'(pc));
      end
      if (cmd_valid) check("valid_implies_busy", 32'(busy), 1);
      pv <= cmd_valid;
      pr <= ready;
      pc <= {cmd_reg, cmd_data};
    end
  end

  task automatic load_rom(input logic [15:0] e0, e1, e2, e3);
    for (int i = 0; i < 256; i++) rom[i] = 16'h7777;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  // Expected command list: walk 0..MAXA, stop on FFFF, skip delay markers.
  task automatic model(output logic [7:0] last);
    exp_q.delete();
    last = 8'd0;
    for (int a = 0; a <= MAXA; a++) begin
      last = 8'(a);
      if (rom[8'(a)] == 16'hFFFF) break;
      if (rom[8'(a)] != 16'h00F0) exp_q.push_back(rom[8'(a)]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  cyc;
    logic prev_busy;
    cyc = 0;
    prev_busy = busy;
    while (!done && cyc < budget) begin
      prev_busy = busy;
      @(negedge clk);
      cyc++;
    end
    check("done_within_budget", 32'(done), 1);
    check("busy_fell_with_done", 32'({prev_busy, busy}), 32'(2'b10));
  endtask

  task automatic run_seq();
    acc_q.delete();
    pulse_start();
    wait_done(500);
  endtask

  task automatic compare_run(input int exp_n, input logic [7:0] exp_last);
    check("write_count", 32'(wcount), 32'(exp_n));
    check("final_addr", 32'(rom_addr), 32'(exp_last));
    check("done_high", 32'(done), 1);
    check("busy_low", 32'(busy), 0);
    check("accepted_cmds", 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      check("cmd_order", 32'(acc_q[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [15:0] rand_entry();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 16'hFFFF;
    if (k == 1) return 16'h00F0;
    if (k == 2) return 16'h0000;
    return 16'($urandom);
  endfunction

  typedef struct {
    logic [15:0] e0, e1, e2, e3;
    int          n_wr;
    logic [7:0]  last;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] mlast;
  int cnt0;

  initial begin
    tbl[0] = '{16'h1280, 16'h1180, 16'hFFFF, 16'h0000, 2, 8'd2};
    tbl[1] = '{16'h00F0, 16'h1204, 16'hFFFF, 16'h0000, 1, 8'd2};
    tbl[2] = '{16'hAA55, 16'hAA55, 16'hAA55, 16'hAA55, 4, 8'd3};
    tbl[3] = '{16'hFFFF, 16'h1280, 16'h1180, 16'h0000, 0, 8'd0};
    tbl[4] = '{16'h0000, 16'h00F0, 16'h00F0, 16'h0000, 2, 8'd3};
    tbl[5] = '{16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 0, 8'd3};

    rst_n = 1'b0; start = 1'b0; ready = 1'b0;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({cmd_valid, busy, done, wcount, rom_addr, cmd_reg, cmd_data}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'({busy, done, cmd_valid}), 0);

    // Table-driven ROM images, ready tied high
    ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      load_rom(tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3);
      model(mlast);
      run_seq();
      compare_run(tbl[t].n_wr, tbl[t].last);
    end

    // Stall for 7 cycles on the first command; check 2-cycle valid latency
    load_rom(16'h1280, 16'h1180, 16'hFFFF, 16'h0000);
    model(mlast);
    ready = 1'b0;
    acc_q.delete();
    pulse_start();
    check("lat_fetch", 32'({busy, cmd_valid, rom_addr}), 32'({1'b1, 1'b0, 8'd0}));
    @(negedge clk);
    check("lat_decode", 32'(cmd_valid), 0);
    @(negedge clk);
    check("lat_send", 32'(cmd_valid), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_cmd", 32'({cmd_valid, cmd_reg, cmd_data}), 32'({1'b1, 16'h1280}));
    end
    ready = 1'b1;
    wait_done(100);
    compare_run(2, 8'd2);

    // Restart after done
    pulse_start();
    check("restart_clears", 32'({done, busy, rom_addr, wcount}), 32'({1'b0, 1'b1, 8'd0, 8'd0}));
    acc_q.delete();
    wait_done(100);
    check("restart_count", 32'(wcount), 2);

    // Delay dwell: FETCH + DECODE + 5 DELAY cycles at address 0
    load_rom(16'h00F0, 16'h1204, 16'hFFFF, 16'h0000);
    model(mlast);
    ready = 1'b1;
    acc_q.delete();
    pulse_start();
    cnt0 = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (busy && rom_addr == 8'd0) cnt0++;
      @(negedge clk);
    end
    check("delay_dwell", 32'(cnt0), 7);
    compare_run(1, 8'd2);

    // start_i ignored during DELAY and SEND
    ready = 1'b0;
    acc_q.delete();
    pulse_start();
    cnt0 = 0;
    for (int c = 0; c < 60 && !cmd_valid; c++) begin
      if (busy && rom_addr == 8'd0) cnt0++;
      start = (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("start_in_delay_ignored", 32'(cnt0), 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_send_ignored", 32'({cmd_valid, busy, rom_addr, cmd_reg, cmd_data}),
          32'({1'b1, 1'b1, 8'd1, 16'h1204}));
    ready = 1'b1;
    wait_done(100);
    compare_run(1, 8'd2);

    // Asynchronous reset while a command is pending
    load_rom(16'h1280, 16'h1180, 16'hFFFF, 16'h0000);
    ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 50 && wcount != 8'd1; c++) @(negedge clk);
    ready = 1'b0;
    for (int c = 0; c < 50 && !cmd_valid; c++) @(negedge clk);
    check("pre_reset_pending", 32'({cmd_valid, wcount}), 32'({1'b1, 8'd1}));
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({cmd_valid, busy, done, wcount}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) @(negedge clk);
    check("stays_idle", 32'({cmd_valid, busy, done, rom_addr}), 0);

    // Randomized ROM images with random back-pressure
    ready_mode = 1;
    for (int r = 0; r < 40; r++) begin
      load_rom(rand_entry(), rand_entry(), rand_entry(), rand_entry());
      model(mlast);
      run_seq();
      compare_run(exp_q.size(), mlast);
    end
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
